// File: rtl/hailstone_trace_monitor.sv
// rtl/hailstone_trace_monitor.sv - snoops RAM stores to one address and checks them against the Collatz rule
// Trace values are queued in a small FIFO; step count, peak and verdict flags are kept alongside.

module hailstone_trace_fifo #(
  parameter int WORD_SIZE  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic [WORD_SIZE-1:0] s_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [WORD_SIZE-1:0] m_tdata,
  output logic                 m_tvalid,
  input  logic                 m_tready
);

  localparam int PTR_W = $clog2(FIFO_DEPTH) + 1;
  localparam int IDX_W = PTR_W - 1;

  logic [WORD_SIZE-1:0] storage [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic                 empty;
  logic                 full;
  logic                 do_push;
  logic                 do_pop;

  // Extra pointer MSB tells a full ring from an empty one when the indices match.
  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[IDX_W-1:0] == rd_ptr[IDX_W-1:0]) &&
                    (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]);
  assign m_tvalid = !empty;
  assign m_tdata  = empty ? '0 : storage[rd_ptr[IDX_W-1:0]];
  assign do_pop   = m_tvalid && m_tready;
  assign s_tready = !full || do_pop;
  assign do_push  = s_tvalid && s_tready;

  always_ff @(posedge clk) begin
    if (do_push && !clear) begin
      storage[wr_ptr[IDX_W-1:0]] <= s_tdata;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
    end
  end

endmodule

module hailstone_trace_monitor #(
  parameter int WORD_SIZE  = 16,
  parameter int ADDR_SIZE  = 8,
  parameter int WATCH_ADDR = 20,
  parameter int FIFO_DEPTH = 8,
  parameter int CNT_SIZE   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 clear,
  input  logic                 mem_we,
  input  logic [ADDR_SIZE-1:0] mem_addr,
  input  logic [WORD_SIZE-1:0] mem_wdata,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] out_data,
  output logic [CNT_SIZE-1:0]  step_count,
  output logic [WORD_SIZE-1:0] peak,
  output logic                 done,
  output logic                 error,
  output logic                 dropped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_TRACK = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;
  localparam logic [1:0] S_ERROR = 2'd3;

  logic [1:0]           state;
  logic [WORD_SIZE-1:0] prev;
  logic [WORD_SIZE-1:0] expected;
  logic                 capture;
  logic                 push_req;
  logic                 fifo_tready;
  logic                 is_one;

  assign capture  = mem_we && (mem_addr == ADDR_SIZE'(WATCH_ADDR));
  assign push_req = capture && ((state == S_IDLE) || (state == S_TRACK));
  assign is_one   = (mem_wdata == WORD_SIZE'(1));

  // 3n+1 wraps at WORD_SIZE, matching what the CPU itself would compute.
  assign expected = prev[0] ? ((prev << 1) + prev + WORD_SIZE'(1)) : (prev >> 1);

  hailstone_trace_fifo #(
    .WORD_SIZE (WORD_SIZE),
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clear   (clear),
    .s_tdata (mem_wdata),
    .s_tvalid(push_req),
    .s_tready(fifo_tready),
    .m_tdata (out_data),
    .m_tvalid(out_valid),
    .m_tready(out_ready)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_IDLE;
      prev       <= '0;
      step_count <= '0;
      peak       <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      dropped    <= 1'b0;
    end else if (clear) begin
      state      <= S_IDLE;
      prev       <= '0;
      step_count <= '0;
      peak       <= '0;
      done       <= 1'b0;
      error      <= 1'b0;
      dropped    <= 1'b0;
    end else begin
      if (push_req && !fifo_tready) begin
        dropped <= 1'b1;
      end
      if (capture) begin
        case (state)
          S_IDLE: begin
            prev <= mem_wdata;
            peak <= mem_wdata;
            if (is_one) begin
              state <= S_DONE;
              done  <= 1'b1;
            end else begin
              state <= S_TRACK;
            end
          end
          S_TRACK: begin
            if (mem_wdata == expected) begin
              prev <= mem_wdata;
              if (step_count != '1) begin
                step_count <= step_count + CNT_SIZE'(1);
              end
              if (mem_wdata > peak) begin
                peak <= mem_wdata;
              end
              if (is_one) begin
                state <= S_DONE;
                done  <= 1'b1;
              end
            end else begin
              error <= 1'b1;
              state <= S_ERROR;
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

endmodule
